// File: rtl/test_sequencer.sv
// Purpose:  riscv-tests campaign controller; loads each image, pulses cpu reset, watches tohost.
// Latency:  verdict write sampled at edge N -> RECORD/cpuReset=1 from N+1, counts visible N+2.
// Backpressure: none; load handshake is loadReq level / loadAck pulse, no timeout on load.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   start                 campaign start pulse, honoured in IDLE/DONE only
//   memWr/memAddr/memIn/wrMask   cpu data-write bus, snooped for the tohost word
//   loadAck               loader finished writing image testIdx
//   cpuReset, loadReq     cpu reset (active high), image load request (level)
//   testIdx, passCount, failCount, firstFailIdx, firstFailCode   campaign results
//   busy, done, allPass   campaign status
module test_sequencer #(
    parameter int          NUM_TESTS      = 38,
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter int          RESET_CYCLES   = 4,
    parameter int          TIMEOUT_CYCLES = 10000,
    localparam int         IDX_W          = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
    localparam int         CNT_W          = $clog2(NUM_TESTS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             memWr,
    input  logic [31:0]      memAddr,
    input  logic [31:0]      memIn,
    input  logic [3:0]       wrMask,
    input  logic             loadAck,
    output logic             cpuReset,
    output logic             loadReq,
    output logic [IDX_W-1:0] testIdx,
    output logic [CNT_W-1:0] passCount,
    output logic [CNT_W-1:0] failCount,
    output logic [IDX_W-1:0] firstFailIdx,
    output logic [30:0]      firstFailCode,
    output logic             busy,
    output logic             done,
    output logic             allPass
);

    localparam int          HOLD_W       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int          TMR_W        = $clog2(TIMEOUT_CYCLES);
    localparam logic [30:0] TIMEOUT_CODE = 31'h7FFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_HOLD, S_RUN, S_RECORD, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   test_idx_q, test_idx_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [IDX_W-1:0]   ffail_idx_q, ffail_idx_d;
    logic [30:0]        ffail_code_q, ffail_code_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               vpass_q, vpass_d;      // verdict carried from RUN into RECORD
    logic [30:0]        vcode_q, vcode_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               load_req_q, load_req_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               all_pass_q, all_pass_d;

    logic               tohost_hit;

    // Only full-word writes to tohost with bit 0 set carry a verdict.
    assign tohost_hit = memWr && (memAddr == TOHOST_ADDR) && (wrMask == 4'hF) && memIn[0];

    always_comb begin
        state_d      = state_q;
        test_idx_d   = test_idx_q;
        pass_cnt_d   = pass_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        ffail_idx_d  = ffail_idx_q;
        ffail_code_d = ffail_code_q;
        hold_cnt_d   = hold_cnt_q;
        timer_d      = timer_q;
        vpass_d      = vpass_q;
        vcode_d      = vcode_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    test_idx_d   = '0;
                    pass_cnt_d   = '0;
                    fail_cnt_d   = '0;
                    ffail_idx_d  = '0;
                    ffail_code_d = '0;
                end
            end
            S_LOAD: begin
                if (loadAck) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_d = S_RUN;
                    timer_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            S_RUN: begin
                timer_d = timer_q + TMR_W'(1);
                // A hit on the final timer cycle still beats the timeout.
                if (tohost_hit) begin
                    state_d = S_RECORD;
                    vpass_d = (memIn == 32'd1);
                    vcode_d = memIn[31:1];
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_RECORD;
                    vpass_d = 1'b0;
                    vcode_d = TIMEOUT_CODE;
                end
            end
            S_RECORD: begin
                if (vpass_q) begin
                    pass_cnt_d = pass_cnt_q + CNT_W'(1);
                end else begin
                    fail_cnt_d = fail_cnt_q + CNT_W'(1);
                    if (fail_cnt_q == '0) begin
                        ffail_idx_d  = test_idx_q;
                        ffail_code_d = vcode_q;
                    end
                end
                if (test_idx_q == IDX_W'(NUM_TESTS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_LOAD;
                    test_idx_d = test_idx_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered from the next state so they line up with it.
        cpu_reset_d = (state_d != S_RUN);
        load_req_d  = (state_d == S_LOAD);
        busy_d      = (state_d == S_LOAD) || (state_d == S_HOLD) ||
                      (state_d == S_RUN)  || (state_d == S_RECORD);
        done_d      = (state_d == S_DONE);
        all_pass_d  = (state_d == S_DONE) && (fail_cnt_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            test_idx_q   <= '0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            ffail_idx_q  <= '0;
            ffail_code_q <= '0;
            hold_cnt_q   <= '0;
            timer_q      <= '0;
            vpass_q      <= 1'b0;
            vcode_q      <= '0;
            cpu_reset_q  <= 1'b1;
            load_req_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            all_pass_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            test_idx_q   <= test_idx_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            ffail_idx_q  <= ffail_idx_d;
            ffail_code_q <= ffail_code_d;
            hold_cnt_q   <= hold_cnt_d;
            timer_q      <= timer_d;
            vpass_q      <= vpass_d;
            vcode_q      <= vcode_d;
            cpu_reset_q  <= cpu_reset_d;
            load_req_q   <= load_req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            all_pass_q   <= all_pass_d;
        end
    end

    assign cpuReset      = cpu_reset_q;
    assign loadReq       = load_req_q;
    assign testIdx       = test_idx_q;
    assign passCount     = pass_cnt_q;
    assign failCount     = fail_cnt_q;
    assign firstFailIdx  = ffail_idx_q;
    assign firstFailCode = ffail_code_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign allPass       = all_pass_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Purpose:  scoreboard bench for test_sequencer; a scripted cpu/loader drives campaigns.
// Latency:  verdicts checked when pass/fail counts move; campaign summary checked on done.
// Backpressure: loader acks after a random 0..3 cycle delay.
module tb_test_sequencer;

    localparam int          NT   = 3;
    localparam logic [31:0] TH   = 32'h0000_1000;
    localparam int          RC   = 4;
    localparam int          TO   = 100;
    localparam int          MAXC = 130;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        memWr = 1'b0;
    logic [31:0] memAddr = '0;
    logic [31:0] memIn = '0;
    logic [3:0]  wrMask = '0;
    logic        loadAck = 1'b0;
    logic        cpuReset, loadReq, busy, done, allPass;
    logic [1:0]  testIdx, passCount, failCount, firstFailIdx;
    logic [30:0] firstFailCode;

    test_sequencer #(
        .NUM_TESTS(NT), .TOHOST_ADDR(TH), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .memWr(memWr), .memAddr(memAddr),
        .memIn(memIn), .wrMask(wrMask), .loadAck(loadAck), .cpuReset(cpuReset),
        .loadReq(loadReq), .testIdx(testIdx), .passCount(passCount), .failCount(failCount),
        .firstFailIdx(firstFailIdx), .firstFailCode(firstFailCode), .busy(busy),
        .done(done), .allPass(allPass)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    typedef struct {
        int          pass_c;
        int          fail_c;
        int          ffi;
        logic [30:0] ffc;
    } exp_t;

    typedef struct {
        int pass_c;
        int fail_c;
        bit all_pass;
    } sum_t;

    wr_t  plan [NT][MAXC+1];
    exp_t exp_q[$];
    sum_t sum_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- plans and reference model ----------------
    function automatic void clear_plan(input int t);
        for (int c = 0; c <= MAXC; c++) plan[t][c] = '{1'b0, 32'h0, 32'h0, 4'h0};
    endfunction

    function automatic void put(input int t, input int c, input bit wr,
                                input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        plan[t][c] = '{wr, a, d, m};
    endfunction

    function automatic void rand_plan(input int t);
        int          mode, k, c, ty;
        logic [31:0] d;
        clear_plan(t);
        mode = $urandom_range(0, 2);
        k    = $urandom_range(1, 120);
        if (mode == 0) put(t, k, 1'b1, TH, 32'd1, 4'hF);
        else if (mode == 1) begin
            d = $urandom | 32'd1;
            if (d == 32'd1) d = 32'd3;
            put(t, k, 1'b1, TH, d, 4'hF);
        end
        repeat ($urandom_range(0, 4)) begin
            c  = $urandom_range(1, 120);
            ty = $urandom_range(0, 3);
            case (ty)
                0: put(t, c, 1'b1, TH, 32'd1, 4'($urandom_range(0, 14)));
                1: put(t, c, 1'b1, TH + 32'd4, 32'd1, 4'hF);
                2: put(t, c, 1'b1, TH, $urandom & 32'hFFFF_FFFE, 4'hF);
                default: put(t, c, 1'b0, TH, 32'd1, 4'hF);
            endcase
        end
    endfunction

    // First full-word odd write to tohost within the timeout window decides; else timeout.
    function automatic void verdict(input int t, output int vc, output bit ok,
                                    output logic [30:0] code);
        bit found = 1'b0;
        vc = TO; ok = 1'b0; code = 31'h7FFF_FFFF;
        for (int c = 1; c <= TO; c++) begin
            if (!found && plan[t][c].wr && plan[t][c].addr == TH &&
                plan[t][c].mask == 4'hF && plan[t][c].data[0]) begin
                found = 1'b1;
                vc    = c;
                ok    = (plan[t][c].data == 32'd1);
                code  = plan[t][c].data[31:1];
            end
        end
    endfunction

    function automatic void push_model();
        int          p = 0, f = 0, fi = 0, vc;
        bit          ok;
        logic [30:0] fc = '0, code;
        for (int t = 0; t < NT; t++) begin
            verdict(t, vc, ok, code);
            if (ok) p++;
            else begin
                if (f == 0) begin fi = t; fc = code; end
                f++;
            end
            exp_q.push_back('{p, f, fi, fc});
        end
        sum_q.push_back('{p, f, (f == 0)});
    endfunction

    // ---------------- monitor ----------------
    int   prev_sum = 0;
    int   streak = 0;
    logic prev_cpu = 1'b1;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        int   s;
        exp_t e;
        sum_t m;
        if (!reset) begin
            prev_sum = 0; streak = 0; prev_cpu = 1'b1; prev_done = 1'b0;
        end else begin
            s = int'(passCount) + int'(failCount);
            if (s > prev_sum) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_verdict: got pass=%0d fail=%0d expected none",
                             passCount, failCount);
                end else begin
                    e = exp_q.pop_front();
                    chk("passCount", 32'(passCount), 32'(e.pass_c));
                    chk("failCount", 32'(failCount), 32'(e.fail_c));
                    chk("firstFailIdx", 32'(firstFailIdx), 32'(e.ffi));
                    chk("firstFailCode", 32'(firstFailCode), 32'(e.ffc));
                end
            end
            prev_sum = s;
            if (prev_cpu && !cpuReset) chk("hold_cycles", 32'(streak), 32'(RC));
            if (cpuReset && !loadReq && busy) streak++;
            else streak = 0;
            prev_cpu = cpuReset;
            if (done && !prev_done) begin
                if (sum_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    m = sum_q.pop_front();
                    chk("done_pass", 32'(passCount), 32'(m.pass_c));
                    chk("done_fail", 32'(failCount), 32'(m.fail_c));
                    chk("allPass", 32'(allPass), 32'(m.all_pass));
                    chk("busy_at_done", 32'(busy), 32'd0);
                end
            end
            prev_done = done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input wr_t w);
        memWr = w.wr; memAddr = w.addr; memIn = w.data; wrMask = w.mask;
    endtask

    task automatic run_test(input int t, input int abort_c, input bit spur, output bit aborted);
        int          n, vc;
        bit          ok;
        logic [30:0] code;
        aborted = 1'b0;
        n = 0;
        while (!loadReq && n < 200) begin @(negedge clk); n++; end
        chk("testIdx_at_load", 32'(testIdx), 32'(t));
        if (!loadReq) return;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        loadAck = 1'b1;
        @(negedge clk);
        loadAck = 1'b0;
        if (spur) begin
            // stray ack plus a valid-looking tohost write while still held in reset
            loadAck = 1'b1;
            drive('{1'b1, TH, 32'd3, 4'hF});
            @(negedge clk);
            loadAck = 1'b0;
            drive('{1'b0, 32'h0, 32'h0, 4'h0});
        end
        n = 0;
        while (cpuReset && n < 20) begin @(negedge clk); n++; end
        chk("run_entered", 32'(cpuReset), 32'd0);
        if (cpuReset) return;
        verdict(t, vc, ok, code);
        for (int c = 1; c <= vc; c++) begin
            if (c == abort_c) begin
                #2 reset = 1'b0;
                aborted = 1'b1;
                drive('{1'b0, 32'h0, 32'h0, 4'h0});
                return;
            end
            if (c == vc) chk("run_until_verdict", 32'(cpuReset), 32'd0);
            drive(plan[t][c]);
            start = (spur && c == 10);
            @(negedge clk);
        end
        drive('{1'b0, 32'h0, 32'h0, 4'h0});
        start = 1'b0;
        chk("verdict_latency_cpuReset", 32'(cpuReset), 32'd1);
    endtask

    task automatic campaign(input int abort_t, input int abort_c, input bit spur);
        bit ab;
        int n;
        push_model();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int t = 0; t < NT; t++) begin
            run_test(t, (t == abort_t) ? abort_c : 0, spur, ab);
            if (ab) begin
                @(negedge clk);
                chk("abort_cpuReset", 32'(cpuReset), 32'd1);
                chk("abort_passCount", 32'(passCount), 32'd0);
                chk("abort_failCount", 32'(failCount), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_testIdx", 32'(testIdx), 32'd0);
                exp_q.delete();
                sum_q.delete();
                @(negedge clk); reset = 1'b1;
                return;
            end
        end
        n = 0;
        while (!done && n < 10) begin @(negedge clk); n++; end
        chk("campaign_done", 32'(done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cpuReset", 32'(cpuReset), 32'd1);
        chk("rst_loadReq", 32'(loadReq), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_allPass", 32'(allPass), 32'd0);
        chk("rst_counts", 32'({passCount, failCount, testIdx, firstFailIdx}), 32'd0);
        chk("rst_code", 32'(firstFailCode), 32'd0);
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);

        // all pass at cycle 50, with stray start/ack and pre-RUN tohost write
        for (int t = 0; t < NT; t++) begin clear_plan(t); put(t, 50, 1'b1, TH, 32'd1, 4'hF); end
        campaign(-1, 0, 1'b1);

        // test 1 fails with code 3
        for (int t = 0; t < NT; t++) clear_plan(t);
        put(0, 20, 1'b1, TH, 32'd1, 4'hF);
        put(1, 30, 1'b1, TH, 32'd7, 4'hF);
        put(2, 40, 1'b1, TH, 32'd1, 4'hF);
        campaign(-1, 0, 1'b0);

        // timeout, hit on the last timer cycle, ignored writes
        for (int t = 0; t < NT; t++) clear_plan(t);
        put(1, 10, 1'b1, TH, 32'd1, 4'h3);
        put(1, 20, 1'b1, TH + 32'd4, 32'd1, 4'hF);
        put(1, 30, 1'b1, TH, 32'd2, 4'hF);
        put(1, 100, 1'b1, TH, 32'd1, 4'hF);
        put(2, 100, 1'b1, TH, 32'd5, 4'hF);
        put(2, 101, 1'b1, TH, 32'd1, 4'hF);
        campaign(-1, 0, 1'b0);

        // reset mid-RUN of test 1, then a fresh campaign from test 0
        for (int t = 0; t < NT; t++) clear_plan(t);
        put(0, 15, 1'b1, TH, 32'd1, 4'hF);
        campaign(1, 20, 1'b0);
        repeat (2) @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            for (int t = 0; t < NT; t++) rand_plan(t);
            campaign(-1, 0, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size() + sum_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
